// File: rtl/io_port_unit.sv
// rtl/io_port_unit.sv - memory-mapped debounced switch / LED port (optional IRQ via IO_PORT_IRQ_EN)
`timescale 1ns/1ps
module io_port_unit #(
    parameter int                SW_W            = 8,
    parameter int                LED_W           = 8,
    parameter int                DATA_W          = 8,
    parameter int                DEBOUNCE_CYCLES = 4,
    parameter logic [LED_W-1:0]  LED_RESET       = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SW_W-1:0]   sw,
    output logic [LED_W-1:0]  leds,
    input  logic [1:0]        addr,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              change_irq
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SW_W-1:0]   r_sync1, r_sync2, r_cand, r_stable;
    logic [CW-1:0]     r_cnt;
    logic              r_chg;
    logic [LED_W-1:0]  r_leds;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] w_sw_ext, w_led_ext, w_status, w_rd;
    logic              w_accept, w_chg_set, w_chg_clr;

    assign w_accept  = (r_sync2 == r_cand) && (r_cnt == CNT_LAST);
    assign w_chg_set = w_accept && (r_cand != r_stable);
    assign w_chg_clr = wr_en && (addr == 2'd2) && wdata[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_cand   <= '0;
            r_cnt    <= '0;
            r_stable <= '0;
            r_chg    <= 1'b0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_cand) begin
                r_cand <= r_sync2;
                r_cnt  <= '0;
            end else if (r_cnt < CNT_MAX) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_accept)
                r_stable <= r_cand;
            // A new change wins over a simultaneous clear so no event is lost
            if (w_chg_set)
                r_chg <= 1'b1;
            else if (w_chg_clr)
                r_chg <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_leds <= LED_RESET;
        end else if (wr_en) begin
            if (addr == 2'd1)
                r_leds <= wdata[LED_W-1:0];
            else if (addr == 2'd3)
                r_leds <= r_leds ^ wdata[LED_W-1:0];
        end
    end

`ifdef IO_PORT_IRQ_EN
    logic r_ie, r_irq;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ie  <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (wr_en && (addr == 2'd2))
                r_ie <= wdata[1];
            r_irq <= r_chg & r_ie;
        end
    end
    assign change_irq = r_irq;
`else
    assign change_irq = 1'b0;
`endif

    always_comb begin
        w_sw_ext  = '0;
        w_sw_ext[SW_W-1:0] = r_stable;
        w_led_ext = '0;
        w_led_ext[LED_W-1:0] = r_leds;
        w_status  = '0;
        w_status[0] = r_chg;
`ifdef IO_PORT_IRQ_EN
        w_status[1] = r_ie;
`endif
        case (addr)
            2'd0:    w_rd = w_sw_ext;
            2'd2:    w_rd = w_status;
            default: w_rd = w_led_ext;
        endcase
    end

    // Read mux sees pre-edge state, so a same-cycle write is not visible yet
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rdata <= '0;
        else if (rd_en)
            r_rdata <= w_rd;
    end

    assign leds  = r_leds;
    assign rdata = r_rdata;
endmodule

// File: tb/tb_io_port_unit.sv
// tb/tb_io_port_unit.sv - directed self-checking bench for io_port_unit
`timescale 1ns/1ps
module tb_io_port_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sw = 8'h00;
    logic [7:0] leds;
    logic [1:0] addr = 2'd0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       change_irq;
    int         total = 0;
    int         bad = 0;
    logic [7:0] rv;

`ifdef IO_PORT_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    io_port_unit #(
        .SW_W(8), .LED_W(8), .DATA_W(8), .DEBOUNCE_CYCLES(4), .LED_RESET(8'hA5)
    ) dut (
        .clk(clk), .rst(rst), .sw(sw), .leds(leds), .addr(addr),
        .wr_en(wr_en), .rd_en(rd_en), .wdata(wdata), .rdata(rdata),
        .change_irq(change_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
        addr = a; wdata = d; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
        addr = a; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        d = rdata;
    endtask

    initial begin
        #12;
        check("rst_leds", leds, 8'hA5);
        check("rst_rdata", rdata, 8'h00);
        check("rst_irq", change_irq, 1'b0);
        rst = 1'b0;
        tick(8);
        bus_rd(2'd0, rv); check("sw_idle", rv, 8'h00);

        // debounce latency: sw changes before edge 1
        sw = 8'h04;
        tick(6);
        check("lat_e6_stable", dut.r_stable, 8'h00);
        check("lat_e6_chg", dut.r_chg, 1'b0);
        tick();
        check("lat_e7_stable", dut.r_stable, 8'h04);
        check("lat_e7_chg", dut.r_chg, 1'b1);
        bus_rd(2'd0, rv); check("lat_rd_sw", rv, 8'h04);
        bus_rd(2'd2, rv); check("lat_rd_status", rv, 8'h01);

        // return to 00 and clear
        sw = 8'h00;
        tick(8);
        bus_wr(2'd2, 8'h01);
        bus_rd(2'd2, rv); check("clr_status", rv, 8'h00);
        bus_rd(2'd0, rv); check("back_sw", rv, 8'h00);

        // glitch rejection
        sw = 8'hFF; tick(3); sw = 8'h00;
        tick(10);
        bus_rd(2'd0, rv); check("glitch_sw", rv, 8'h00);
        bus_rd(2'd2, rv); check("glitch_chg", rv, 8'h00);
        sw = 8'hFF;
        tick(8);
        bus_rd(2'd0, rv); check("accept_ff", rv, 8'hFF);
        bus_rd(2'd2, rv); check("accept_chg", rv, 8'h01);
        bus_wr(2'd2, 8'h01);

        // W1C on the acceptance edge
        sw = 8'h00;
        tick(6);
        bus_wr(2'd2, 8'h01);
        check("race_stable", dut.r_stable, 8'h00);
        check("race_chg", dut.r_chg, 1'b1);
        bus_wr(2'd2, 8'h01);
        bus_rd(2'd2, rv); check("race_clr2", rv, 8'h00);

        // LED register and toggle alias
        bus_wr(2'd1, 8'h3C); check("led_wr", leds, 8'h3C);
        bus_rd(2'd1, rv); check("led_rd", rv, 8'h3C);
        bus_wr(2'd3, 8'h0F); check("led_tgl", leds, 8'h33);
        bus_rd(2'd3, rv); check("tgl_rd", rv, 8'h33);
        addr = 2'd1; wdata = 8'h55; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("rw_same_rdata", rdata, 8'h33);
        check("rw_same_leds", leds, 8'h55);
        tick(2); check("rdata_hold", rdata, 8'h33);
        bus_wr(2'd0, 8'hAA);
        bus_rd(2'd0, rv); check("sw_ro", rv, 8'h00);

        // interrupt path
        bus_wr(2'd2, 8'h02);
        bus_rd(2'd2, rv); check("ie_rd", rv, {6'd0, IRQ_ON, 1'b0});
        sw = 8'h81;
        tick(7);
        check("irq_chg", dut.r_chg, 1'b1);
        check("irq_e7", change_irq, 1'b0);
        tick();
        check("irq_rise", change_irq, IRQ_ON);
        bus_wr(2'd2, 8'h03);
        check("irq_clr_chg", dut.r_chg, 1'b0);
        check("irq_hold", change_irq, IRQ_ON);
        tick();
        check("irq_fall", change_irq, 1'b0);

        // async reset mid-cycle and mid-debounce
        bus_rd(2'd1, rv);
        sw = 8'h3F;
        tick(4);
        #3 rst = 1'b1;
        #1;
        check("arst_leds", leds, 8'hA5);
        check("arst_rdata", rdata, 8'h00);
        check("arst_irq", change_irq, 1'b0);
        check("arst_cand", dut.r_cand, 8'h00);
        sw = 8'h00;
        tick();
        rst = 1'b0;
        tick(8);
        bus_rd(2'd0, rv); check("arst_sw", rv, 8'h00);
        bus_rd(2'd2, rv); check("arst_status", rv, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/io_port_unit.md
# io_port_unit

Memory-mapped switch/LED port for the unicycle processor, replacing direct `sw`/`leds` wiring at the processor boundary. Switch inputs pass through a two-flop synchroniser and a parametrised debounce filter, and a change flag is raised whenever the debounced value changes. LEDs are driven from a read/write register with an XOR-toggle alias. The processor reaches all registers over a simple single-cycle load/store bus.

## Interface
- `SW_W`, 8, number of switch inputs (1..DATA_W)
- `LED_W`, 8, number of LED outputs (1..DATA_W)
- `DATA_W`, 8, bus data width
- `DEBOUNCE_CYCLES`, 4, consecutive stable cycles required to accept a switch value (>=1)
- `LED_RESET`, 0, LED register value after reset (LED_W bits)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `sw`  in  SW_W  raw asynchronous switch inputs
- `leds`  out  LED_W  LED register contents
- `addr`  in  2  register select
- `wr_en`  in  1  write strobe, one cycle per write
- `rd_en`  in  1  read strobe, one cycle per read
- `wdata`  in  DATA_W  write data
- `rdata`  out  DATA_W  registered read data
- `change_irq`  out  1  level interrupt (see Configuration)

## Operation
- Synchroniser: `sync1 <= sw`, `sync2 <= sync1`.
- Debounce uses one shared filter for the whole vector, with registers `cand` (SW_W), `cnt` (0..DEBOUNCE_CYCLES, saturating) and `stable` (SW_W).
  - If `sync2 != cand`: load `cand <= sync2`, `cnt <= 0`.
  - Else if `cnt < DEBOUNCE_CYCLES`: increment `cnt`.
  - On the edge where `cnt` goes from DEBOUNCE_CYCLES-1 to DEBOUNCE_CYCLES: `stable <= cand`. If `cand != stable`, set `chg`.
- Register map, with unused read bits reading 0:
  - 0 SW: RO; returns `stable`, zero-extended. Writes are ignored.
  - 1 LED: RW; a write loads `wdata[LED_W-1:0]`.
  - 2 STATUS: bit0 `chg` is write-1-to-clear. bit1 `ie` is RW; it exists only with the macro and reads 0 otherwise.
  - 3 LED_TGL: write XORs `wdata[LED_W-1:0]` into LED. Reads return the LED value.
- Simultaneous events:
  - A `chg` set and a W1C clear in the same cycle: set wins, and `chg` stays 1.
  - `wr_en` and `rd_en` both high on the same address: the read returns the pre-write value.
- Reset values:
  - `sync1`, `sync2`, `cand`, `stable`, `cnt`, `chg`, `ie` = 0.
  - `leds` = LED_RESET.
  - `rdata` = 0.
  - `change_irq` = 0.
- Reset mid-debounce abandons the pending value. After release, the filter restarts from `cand` = 0.

## Timing
- Switch latency: `sw` changes before edge 1 and is then held. `sync2` shows the new value after edge 2, `cand` after edge 3, and `stable` after edge 3+DEBOUNCE_CYCLES.
  - With DEBOUNCE_CYCLES=4, that is 7 edges.
  - `chg` rises on the same edge as `stable`.
- Glitch rejection: a `sync2` pulse shorter than DEBOUNCE_CYCLES cycles never reaches `stable`. Any mismatch restarts the count.
- Writes take effect on the edge where `wr_en` is sampled high; `leds` updates on that edge.
- Reads: `rdata` loads on the edge where `rd_en` is sampled high, giving one-cycle latency. `rdata` holds its value while `rd_en` is low.
- `change_irq` is registered and asserts one edge after `chg`/`ie` satisfy its condition.

## Configuration
- `IO_PORT_IRQ_EN` defined:
  - STATUS bit1 `ie` is implemented.
  - `change_irq` is registered as `chg & ie` and deasserts one edge after `chg` is cleared or `ie` is cleared.
- Undefined:
  - `ie` is absent and reads 0.
  - `change_irq` is tied to 0.
  - `chg` remains pollable.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle with LED_RESET=8'hA5. Outputs change immediately to `leds`=A5, `rdata`=0, `change_irq`=0; SW reads 0.
- Debounce latency: DEBOUNCE_CYCLES=4, `sw` 00→04 before edge 1 and held. `stable`=04 and `chg`=1 after edge 7, not after edge 6. A read of addr 0 returns 8'h04.
- Glitch rejection: `sw`=FF for 3 cycles, then back to 00. SW stays 00 and `chg` stays 0. A following 4-cycle-stable FF is accepted.
- LED register and toggle:
  - Write LED=3C; `leds`=3C on the same edge, and a read returns 3C one cycle after `rd_en`.
  - Write LED_TGL=0F; `leds`=33.
- W1C race: write STATUS=01 on the exact edge a new switch value is accepted. `chg` remains 1; a second W1C clears it to 0.
- IRQ (macro on): set `ie`=1, then change the switch. `change_irq` rises one edge after `chg`, and falls one edge after the W1C. With the macro off, `change_irq` is 0 throughout the same sequence.
